// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the FP unit arbiter: FSM encoding, word width, timeout substitute.
package fp_arb_pkg;

  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FURST  = 3'd1,
    S_FEED_A = 3'd2,
    S_FEED_B = 3'd3,
    S_WAIT_Z = 3'd4,
    S_RSP    = 3'd5
  } state_e;

endpackage

// File: rtl/fp_unit_arbiter_if.sv
// Bundle of requester-side and FU-side signals of the arbiter; master is the arbiter's view.
interface fp_unit_arbiter_if #(
  parameter int N_REQ = 4
) ();
  import fp_arb_pkg::*;

  logic [N_REQ-1:0]      req_stb;
  logic [FP_W*N_REQ-1:0] req_a;
  logic [FP_W*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]      req_ack;
  logic [FP_W-1:0]       rsp_z;
  logic                  rsp_err;
  logic [N_REQ-1:0]      rsp_stb;
  logic [N_REQ-1:0]      rsp_ack;
  logic                  fu_rst;
  logic [FP_W-1:0]       fu_a;
  logic [FP_W-1:0]       fu_b;
  logic                  fu_a_stb;
  logic                  fu_b_stb;
  logic                  fu_a_ack;
  logic                  fu_b_ack;
  logic [FP_W-1:0]       fu_z;
  logic                  fu_z_stb;
  logic                  fu_z_ack;
  logic                  busy;

  modport master (
    input  req_stb, req_a, req_b, rsp_ack, fu_a_ack, fu_b_ack, fu_z, fu_z_stb,
    output req_ack, rsp_z, rsp_err, rsp_stb, fu_rst, fu_a, fu_b, fu_a_stb, fu_b_stb,
           fu_z_ack, busy
  );

  modport slave (
    output req_stb, req_a, req_b, rsp_ack, fu_a_ack, fu_b_ack, fu_z, fu_z_stb,
    input  req_ack, rsp_z, rsp_err, rsp_stb, fu_rst, fu_a, fu_b, fu_a_stb, fu_b_stb,
           fu_z_ack, busy
  );

endinterface

// File: rtl/fp_unit_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request scanning ptr+1, ptr+2, ... modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  logic [ID_W-1:0]  cand [N_REQ];
  logic [N_REQ-1:0] hit;

  // cand[k] is the requester k+1 positions after the pointer, wrapped into range
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_off
    logic [ID_W:0] sum;
    assign sum      = {1'b0, ptr} + (ID_W+1)'(gi + 1);
    assign cand[gi] = (sum >= (ID_W+1)'(N_REQ)) ? ID_W'(sum - (ID_W+1)'(N_REQ))
                                                : sum[ID_W-1:0];
    assign hit[gi]  = req[cand[gi]];
  end

  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (hit[i]) begin
        valid = 1'b1;
        id    = cand[i];
      end
    end
  end

endmodule

// File: rtl/fp_unit_arbiter.sv
// Shares one stb/ack FP unit among N_REQ requesters, one operation at a time, round-robin.
// Optional FU watchdog enabled by defining FP_ARB_TIMEOUT_EN.
module fp_unit_arbiter
  import fp_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ID_W        = $clog2(N_REQ),
  parameter int TIMEOUT_CYC = 64
) (
  input logic               clk,
  input logic               rst_n,
  fp_unit_arbiter_if.master bus
);

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [FP_W-1:0]  a_q, a_d;
  logic [FP_W-1:0]  b_q, b_d;
  logic [FP_W-1:0]  rsp_z_q, rsp_z_d;
  logic             rsp_err_q, rsp_err_d;
  logic [N_REQ-1:0] req_ack_q, req_ack_d;
  logic [N_REQ-1:0] rsp_stb_q, rsp_stb_d;
  logic             fu_rst_q, fu_rst_d;
  logic             fu_a_stb_q, fu_a_stb_d;
  logic             fu_b_stb_q, fu_b_stb_d;
  logic             fu_z_ack_q, fu_z_ack_d;
  logic             busy_q, busy_d;

`ifdef FP_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic [FP_W-1:0] slot_a [N_REQ];
  logic [FP_W-1:0] slot_b [N_REQ];
  logic            pick_valid;
  logic [ID_W-1:0] pick_id;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
    assign slot_a[gi] = bus.req_a[FP_W*gi +: FP_W];
    assign slot_b[gi] = bus.req_b[FP_W*gi +: FP_W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req   (bus.req_stb),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .id    (pick_id)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_z_d    = rsp_z_q;
    rsp_err_d  = rsp_err_q;
    req_ack_d  = '0;
    rsp_stb_d  = rsp_stb_q;
    fu_rst_d   = fu_rst_q;
    fu_a_stb_d = fu_a_stb_q;
    fu_b_stb_d = fu_b_stb_q;
    fu_z_ack_d = 1'b0;
`ifdef FP_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          id_d      = pick_id;
          a_d       = slot_a[pick_id];
          b_d       = slot_b[pick_id];
          req_ack_d = ONE << pick_id;
          fu_rst_d  = 1'b1;
          rsp_err_d = 1'b0;
          state_d   = S_FURST;
        end
      end
      S_FURST: begin
        fu_rst_d   = 1'b0;
        fu_a_stb_d = 1'b1;
        state_d    = S_FEED_A;
`ifdef FP_ARB_TIMEOUT_EN
        cnt_d      = '0;
`endif
      end
      S_FEED_A: begin
        if (bus.fu_a_ack) begin
          fu_a_stb_d = 1'b0;
          fu_b_stb_d = 1'b1;
          state_d    = S_FEED_B;
        end
      end
      S_FEED_B: begin
        if (bus.fu_b_ack) begin
          fu_b_stb_d = 1'b0;
          state_d    = S_WAIT_Z;
        end
      end
      S_WAIT_Z: begin
        if (bus.fu_z_stb) begin
          rsp_z_d    = bus.fu_z;
          rsp_err_d  = 1'b0;
          fu_z_ack_d = 1'b1;
          rsp_stb_d  = ONE << id_q;
          state_d    = S_RSP;
        end
      end
      S_RSP: begin
        // ends a watchdog fu_rst pulse; a normal result never raised it here
        fu_rst_d = 1'b0;
        if (bus.rsp_ack[id_q]) begin
          rsp_stb_d = '0;
          rsp_err_d = 1'b0;
          ptr_d     = id_q;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef FP_ARB_TIMEOUT_EN
    // a real result arriving on the limit cycle wins over the substitute
    if (state_q == S_FEED_A || state_q == S_FEED_B || state_q == S_WAIT_Z) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST && state_d != S_RSP) begin
        fu_a_stb_d = 1'b0;
        fu_b_stb_d = 1'b0;
        fu_rst_d   = 1'b1;
        rsp_z_d    = FP_QNAN;
        rsp_err_d  = 1'b1;
        rsp_stb_d  = ONE << id_q;
        state_d    = S_RSP;
      end
    end
`endif

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= ID_W'(N_REQ - 1);
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_z_q    <= '0;
      rsp_err_q  <= 1'b0;
      req_ack_q  <= '0;
      rsp_stb_q  <= '0;
      fu_rst_q   <= 1'b1;
      fu_a_stb_q <= 1'b0;
      fu_b_stb_q <= 1'b0;
      fu_z_ack_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef FP_ARB_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_z_q    <= rsp_z_d;
      rsp_err_q  <= rsp_err_d;
      req_ack_q  <= req_ack_d;
      rsp_stb_q  <= rsp_stb_d;
      fu_rst_q   <= fu_rst_d;
      fu_a_stb_q <= fu_a_stb_d;
      fu_b_stb_q <= fu_b_stb_d;
      fu_z_ack_q <= fu_z_ack_d;
      busy_q     <= busy_d;
`ifdef FP_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus.req_ack  = req_ack_q;
  assign bus.rsp_z    = rsp_z_q;
  assign bus.rsp_err  = rsp_err_q;
  assign bus.rsp_stb  = rsp_stb_q;
  assign bus.fu_rst   = fu_rst_q;
  assign bus.fu_a     = a_q;
  assign bus.fu_b     = b_q;
  assign bus.fu_a_stb = fu_a_stb_q;
  assign bus.fu_b_stb = fu_b_stb_q;
  assign bus.fu_z_ack = fu_z_ack_q;
  assign bus.busy     = busy_q;

endmodule
